// File: rtl/tea_decrypt.sv
// Iterative TEA block decryptor: one round per clock, 32 rounds per block, valid/ready on both sides.
// Optional job cancel input is compiled in when TEA_DEC_ABORT_EN is defined.
module tea_decrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  plaintext,
    output logic         busy
`ifdef TEA_DEC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    localparam logic [31:0] DELTA    = 32'h9E37_79B9;
    localparam logic [31:0] SUM_INIT = 32'hC6EF_3720;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state_q;
    logic [31:0]  y_q;
    logic [31:0]  z_q;
    logic [31:0]  sum_q;
    logic [4:0]   ctr_q;
    logic [127:0] key_q;
    logic         out_valid_q;
    logic [63:0]  plaintext_q;

    logic [31:0]  y_d;
    logic [31:0]  z_d;
    logic [31:0]  sum_d;
    logic         abort_req;

`ifdef TEA_DEC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Cancel outranks acceptance, so the block never offers readiness while abort is asserted.
    assign in_ready  = (state_q == IDLE) && !rst && !abort_req;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign plaintext = plaintext_q;

    // One full decryption round; z' feeds y' within the same cycle.
    always_comb begin
        logic [31:0] k0, k1, k2, k3;
        k0    = key_q[127:96];
        k1    = key_q[95:64];
        k2    = key_q[63:32];
        k3    = key_q[31:0];
        z_d   = z_q - (((y_q << 4) + k2) ^ (y_q + sum_q) ^ ((y_q >> 5) + k3));
        y_d   = y_q - (((z_d << 4) + k0) ^ (z_d + sum_q) ^ ((z_d >> 5) + k1));
        sum_d = sum_q - DELTA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath and key registers are cleared too, so no key material survives a reset.
            state_q     <= IDLE;
            y_q         <= '0;
            z_q         <= '0;
            sum_q       <= '0;
            ctr_q       <= '0;
            key_q       <= '0;
            out_valid_q <= 1'b0;
            plaintext_q <= '0;
        end else if (abort_req && state_q != IDLE) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            plaintext_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        y_q     <= ciphertext[63:32];
                        z_q     <= ciphertext[31:0];
                        key_q   <= key;
                        sum_q   <= SUM_INIT;
                        ctr_q   <= 5'd31;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    y_q   <= y_d;
                    z_q   <= z_d;
                    sum_q <= sum_d;
                    ctr_q <= ctr_q - 5'd1;
                    if (ctr_q == 5'd0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        plaintext_q <= {y_d, z_d};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tea_decrypt.sv
// Scoreboard bench for tea_decrypt: directed zero-key vector, backpressure, input isolation,
// mid-job reset, optional abort (TEA_DEC_ABORT_EN) and a randomised encrypt/decrypt round trip.
module tb_tea_decrypt;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  plaintext;
    logic         busy;
`ifdef TEA_DEC_ABORT_EN
    logic         abort;
`endif

    tea_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
`ifdef TEA_DEC_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [63:0] ZERO_CT = 64'h41EA_3A0A_94BA_A940;

    typedef struct {
        logic [63:0] pt;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
        logic [31:0] y, z, s;
        y = p[63:32];
        z = p[31:0];
        s = 32'h0;
        for (int r = 0; r < 32; r++) begin
            s = s + 32'h9E37_79B9;
            y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
            z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
        end
        return {y, z};
    endfunction

    // Monitor: compares every cycle a result is presented, pops on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                fail("spurious_result");
            end else begin
                if (!ov_prev) check("latency", 64'(cyc - sb[0].acc), 64'd32);
                check("plaintext", plaintext, sb[0].pt);
                check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                if (out_ready) void'(sb.pop_front());
            end
        end
        ov_prev = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] ct, input logic [127:0] k, input logic [63:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            fail("in_ready_timeout");
        end else begin
            in_valid   = 1'b1;
            ciphertext = ct;
            key        = k;
            tick();
            in_valid = 1'b0;
            sb.push_back('{pt: exp, acc: cyc});
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0 || busy) fail(name);
    endtask

    initial begin
        logic [127:0] k;
        logic [63:0]  p;
        int           n;

        rst        = 1'b1;
        in_valid   = 1'b0;
        ciphertext = '0;
        key        = '0;
        out_ready  = 1'b1;
`ifdef TEA_DEC_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (3) tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_plaintext", plaintext, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

        // Zero-key directed vector.
        send(ZERO_CT, 128'd0, 64'd0);
        check("busy_in_run", {63'd0, busy}, 64'd1);
        wait_drain("drain_zero_vec");

        // Backpressure: result held for 10 cycles, then released.
        out_ready = 1'b0;
        send(ZERO_CT, 128'd0, 64'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!out_valid) fail("bp_out_valid_timeout");
        repeat (10) tick();
        out_ready = 1'b1;
        tick();
        check("bp_out_valid_fall", {63'd0, out_valid}, 64'd0);
        check("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        check("bp_plaintext_kept", plaintext, 64'd0);
        wait_drain("drain_bp");

        // Input isolation: scramble inputs while the job runs.
        send(ZERO_CT, 128'd0, 64'd0);
        for (int i = 0; i < 30; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            ciphertext = {$urandom, $urandom};
            key        = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        wait_drain("drain_isolation");

        // Reset in the middle of a job: no result may appear.
        send(ZERO_CT, 128'd0, 64'd0);
        repeat (15) tick();
        rst = 1'b1;
        sb.delete();
        tick();
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_plaintext", plaintext, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) tick();

`ifdef TEA_DEC_ABORT_EN
        // Abort during RUN: back to IDLE, nothing delivered, next job fine.
        send(ZERO_CT, 128'd0, 64'd0);
        repeat (20) tick();
        abort = 1'b1;
        sb.delete();
        tick();
        abort = 1'b0;
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) tick();
        send(ZERO_CT, 128'd0, 64'd0);
        wait_drain("drain_after_abort");
`endif

        // Round trip with the bench encryptor, issued back-to-back.
        for (int i = 0; i < 1000; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom};
            send(tea_enc(p, k), k, p);
        end
        wait_drain("drain_round_trip");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tea_decrypt.md
TEA_DECRYPT -- requirements
Module: tea_decrypt

Interface
REQ-001 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 Port rst, input, 1, reset; synchronous and active-high.
REQ-003 Port in_valid, input, 1, ciphertext/key offer from upstream.
REQ-004 Port in_ready, output, 1, block can accept a new job.
REQ-005 Port ciphertext, input, 64, block to decrypt; [63:32]=y, [31:0]=z.
REQ-006 Port key, input, 128, k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
REQ-007 Port out_valid, output, 1, plaintext result available.
REQ-008 Port out_ready, input, 1, downstream accepts the result.
REQ-009 Port plaintext, output, 64, decrypted block {y,z}.
REQ-010 Port busy, output, 1, high in RUN or DONE.
REQ-011 Port abort, input, 1, job cancel; present only when TEA_DEC_ABORT_EN is defined.

Function
REQ-012 The block SHALL implement standard TEA decryption: 32 rounds, delta 32'h9E3779B9, initial sum 32'hC6EF3720.
REQ-013 Each round SHALL compute z' = z - (((y<<4)+k2) ^ (y+sum) ^ ((y>>5)+k3)), then y' = y - (((z'<<4)+k0) ^ (z'+sum) ^ ((z'>>5)+k1)), then sum' = sum - delta; all arithmetic modulo 2^32, logical shifts.
REQ-014 Exactly one round SHALL execute per clock in RUN; the z' to y' dependency is resolved combinationally within the cycle.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 in_ready SHALL equal (state==IDLE); in_ready SHALL never be high in RUN or DONE.
REQ-017 IDLE->RUN on in_valid && in_ready: latch y, z and all 128 key bits, load sum=32'hC6EF3720, load round counter=31.
REQ-018 Latched key and data SHALL be used for the whole job; input changes after acceptance SHALL have no effect.
REQ-019 RUN: each cycle apply one round and decrement the counter; in the cycle the counter is 0, apply the final round and go to DONE.
REQ-020 Latency: job accepted at edge N -> out_valid high after edge N+32.
REQ-021 DONE: out_valid=1; plaintext SHALL hold stable until out_valid && out_ready.
REQ-022 DONE->IDLE on out_ready; out_valid falls at that edge; plaintext keeps its last value.
REQ-023 out_ready high in IDLE or RUN SHALL be ignored.
REQ-024 in_valid high outside IDLE SHALL be ignored; no job is queued.
REQ-025 Back-to-back: a new job MAY be accepted in the cycle after the DONE->IDLE handshake, giving a minimum issue interval of 34 cycles.

Reset
REQ-026 With rst high at an edge, state=IDLE, out_valid=0, plaintext=0, busy=0, and internal y, z, sum, counter and key registers=0.
REQ-027 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-028 rst SHALL override every other input and SHALL abandon a job in progress in RUN or DONE without producing a result.

Configuration
REQ-029 Macro TEA_DEC_ABORT_EN SHALL control the abort feature.
REQ-030 With TEA_DEC_ABORT_EN defined: abort high at an edge in RUN or DONE -> IDLE, out_valid=0, plaintext=0, with no result delivered.
REQ-031 With TEA_DEC_ABORT_EN defined: abort in IDLE is ignored, and abort SHALL take priority over acceptance in the same cycle.
REQ-032 Without TEA_DEC_ABORT_EN: the abort port does not exist and all other behaviour is unchanged.

Verification
REQ-033 Zero-key vector: key=0, ciphertext=64'h41EA3A0A94BAA940 accepted at edge N -> out_valid after edge N+32, plaintext=64'h0.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> plaintext stable, in_ready=0; raise out_ready -> IDLE in 1 cycle.
REQ-035 Input isolation: change key and ciphertext every cycle during RUN -> plaintext still 64'h0 for the vector in REQ-033.
REQ-036 Reset mid-job: assert rst at round 15 -> next cycle out_valid=0, plaintext=0, in_ready=1 after release; no result emitted.
REQ-037 Round trip: 1000 random key/plaintext pairs encrypted by the bench model and decrypted by the DUT -> plaintext equals original, each result at exactly 32-cycle latency.
REQ-038 TEA_DEC_ABORT_EN build: abort at cycle 20 of RUN -> IDLE next cycle, out_valid never rises; next job decrypts correctly.
